seq_alu_core: RTL and testbench

//  Registered, multi-cycle ALU; parametrised successor to the combinational ALU circuits.

---
 rtl/seq_alu_if.sv | 30 +++
 rtl/seq_alu_core.sv | 254 +++++++++++++++++++++++++
 tb/tb_seq_alu_core.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/seq_alu_if.sv
// Request/response bundle of the sequential ALU. The master side issues the
// operation and consumes the result. The slave side is the ALU core.
interface seq_alu_if #(
    parameter int WIDTH = 20,
    parameter int SHW   = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op;
    logic             mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [SHW-1:0]   shamt;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             flag_z;
    logic             flag_s;
    logic             flag_c;

    modport master (
        output in_valid, op, mode, a, b, shamt, out_ready,
        input  in_ready, out_valid, result, flag_z, flag_s, flag_c
    );

    modport slave (
        input  in_valid, op, mode, a, b, shamt, out_ready,
        output in_ready, out_valid, result, flag_z, flag_s, flag_c
    );
endinterface

// File: rtl/seq_alu_core.sv
// Registered multi-cycle ALU. It runs one operation per valid/ready handshake
// in full-word or half-word mode. Shifts and rotates run one bit per cycle.
// The Z/S/C status register persists between operations and feeds ADC/SBC.
module seq_alu_core #(
    parameter int WIDTH = 20,
    parameter int SHW   = 5
) (
    input  logic     clk,
    input  logic     rst_n,
    seq_alu_if.slave bus
);
    localparam int HW = WIDTH / 2;

    localparam logic [WIDTH-1:0] HALF_MASK = {{(WIDTH-HW){1'b0}}, {HW{1'b1}}};
    localparam logic [WIDTH-1:0] FULL_MASK = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ZERO_W    = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_W     = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] TOP_FULL  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] TOP_HALF  = {{(WIDTH-HW){1'b0}}, 1'b1, {(HW-1){1'b0}}};
    localparam logic [SHW-1:0]   CNT_FULL  = SHW'(WIDTH);
    localparam logic [SHW-1:0]   CNT_HALF  = SHW'(HW);
    localparam logic [SHW-1:0]   CNT_ONE   = {{(SHW-1){1'b0}}, 1'b1};
    localparam logic [SHW-1:0]   CNT_ZERO  = {SHW{1'b0}};

    localparam logic [3:0] OP_NOT = 4'h0, OP_AND = 4'h1, OP_OR  = 4'h2, OP_XOR = 4'h3;
    localparam logic [3:0] OP_ADD = 4'h4, OP_ADC = 4'h5, OP_SUB = 4'h6, OP_SBC = 4'h7;
    localparam logic [3:0] OP_INC = 4'h8, OP_DEC = 4'h9, OP_SHL = 4'hA, OP_SHR = 4'hB;
    localparam logic [3:0] OP_ROL = 4'hC, OP_ROR = 4'hD, OP_CMP = 4'hE, OP_NOP = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    // Trim a value to the active word: half mode keeps only the low HW bits.
    function automatic logic [WIDTH-1:0] fit_word(input logic [WIDTH-1:0] v, input logic md);
        return md ? v : (v & HALF_MASK);
    endfunction

    // The MSB of the active word acts as the sign.
    function automatic logic sign_bit(input logic [WIDTH-1:0] v, input logic md);
        return md ? v[WIDTH-1] : v[HW-1];
    endfunction

    state_t           r_state;
    logic [WIDTH-1:0] r_work;
    logic [SHW-1:0]   r_cnt;
    logic [3:0]       r_op;
    logic             r_mode;
    logic [WIDTH-1:0] r_result;
    logic             r_out_valid;
    logic             r_z;
    logic             r_s;
    logic             r_c;

    logic [WIDTH-1:0] w_a_m;
    logic [WIDTH-1:0] w_b_m;
    logic [SHW-1:0]   w_lim;
    logic [SHW-1:0]   w_cnt;
    logic             w_is_shift;
    logic             w_cin;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_res_raw;
    logic [WIDTH-1:0] w_res;
    logic             w_z;
    logic             w_s;
    logic             w_c;
    logic             w_c_upd;
    logic             w_f_upd;

    logic             w_msb;
    logic [WIDTH-1:0] w_top;
    logic [WIDTH-1:0] w_step_raw;
    logic [WIDTH-1:0] w_step;
    logic             w_step_out;

    assign bus.in_ready  = (r_state == ST_IDLE) && rst_n;
    assign bus.out_valid = r_out_valid;
    assign bus.result    = r_result;
    assign bus.flag_z    = r_z;
    assign bus.flag_s    = r_s;
    assign bus.flag_c    = r_c;

    // Single-cycle result and flag candidates, computed from the request presented at accept.
    always_comb begin
        w_a_m      = fit_word(bus.a, bus.mode);
        w_b_m      = fit_word(bus.b, bus.mode);
        w_lim      = bus.mode ? CNT_FULL : CNT_HALF;
        if (bus.shamt > w_lim) begin
            w_cnt = w_lim;
        end else begin
            w_cnt = bus.shamt;
        end
        w_is_shift = (bus.op == OP_SHL) || (bus.op == OP_SHR) ||
                     (bus.op == OP_ROL) || (bus.op == OP_ROR);
        w_cin      = ((bus.op == OP_ADC) || (bus.op == OP_SBC)) ? r_c : 1'b0;
        // Operands above the active word are zero, so bit WIDTH of the
        // difference is the borrow in both modes.
        w_sum      = {1'b0, w_a_m} + {1'b0, w_b_m} + {{WIDTH{1'b0}}, w_cin};
        w_diff     = {1'b0, w_a_m} - {1'b0, w_b_m} - {{WIDTH{1'b0}}, w_cin};
        w_res_raw  = ZERO_W;
        w_c        = r_c;
        w_c_upd    = 1'b0;
        w_f_upd    = 1'b1;
        case (bus.op)
            OP_NOT: w_res_raw = ~w_a_m;
            OP_AND: w_res_raw = w_a_m & w_b_m;
            OP_OR:  w_res_raw = w_a_m | w_b_m;
            OP_XOR: w_res_raw = w_a_m ^ w_b_m;
            OP_ADD, OP_ADC: begin
                w_res_raw = w_sum[WIDTH-1:0];
                w_c       = bus.mode ? w_sum[WIDTH] : w_sum[HW];
                w_c_upd   = 1'b1;
            end
            OP_SUB, OP_SBC: begin
                w_res_raw = w_diff[WIDTH-1:0];
                w_c       = w_diff[WIDTH];
                w_c_upd   = 1'b1;
            end
            OP_INC: begin
                w_res_raw = w_a_m + ONE_W;
                w_c       = (w_a_m == (bus.mode ? FULL_MASK : HALF_MASK));
                w_c_upd   = 1'b1;
            end
            OP_DEC: begin
                w_res_raw = w_a_m - ONE_W;
                w_c       = (w_a_m == ZERO_W);
                w_c_upd   = 1'b1;
            end
            OP_SHL, OP_SHR, OP_ROL, OP_ROR: w_res_raw = w_a_m;
            OP_CMP: w_res_raw = w_a_m;
            OP_NOP: begin
                w_res_raw = ZERO_W;
                w_f_upd   = 1'b0;
            end
            default: begin
                w_res_raw = ZERO_W;
                w_f_upd   = 1'b0;
            end
        endcase
        w_res = fit_word(w_res_raw, bus.mode);
        if (bus.op == OP_CMP) begin
            w_z = (w_a_m == w_b_m);
            w_s = (w_a_m < w_b_m);
        end else begin
            w_z = (w_res == ZERO_W);
            w_s = sign_bit(w_res, bus.mode);
        end
    end

    // One-bit shift/rotate step applied to the working register while in EXEC.
    always_comb begin
        w_msb = sign_bit(r_work, r_mode);
        w_top = r_mode ? TOP_FULL : TOP_HALF;
        case (r_op)
            OP_SHL: begin
                w_step_raw = r_work << 1;
                w_step_out = w_msb;
            end
            OP_SHR: begin
                w_step_raw = r_work >> 1;
                w_step_out = r_work[0];
            end
            OP_ROL: begin
                w_step_raw = (r_work << 1) | (w_msb ? ONE_W : ZERO_W);
                w_step_out = w_msb;
            end
            OP_ROR: begin
                w_step_raw = (r_work >> 1) | (r_work[0] ? w_top : ZERO_W);
                w_step_out = r_work[0];
            end
            default: begin
                w_step_raw = r_work;
                w_step_out = 1'b0;
            end
        endcase
        w_step = fit_word(w_step_raw, r_mode);
    end

    // Control FSM with the result, status and working registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_work      <= ZERO_W;
            r_cnt       <= CNT_ZERO;
            r_op        <= OP_NOP;
            r_mode      <= 1'b0;
            r_result    <= ZERO_W;
            r_out_valid <= 1'b0;
            r_z         <= 1'b0;
            r_s         <= 1'b0;
            r_c         <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        if (w_is_shift && (w_cnt != CNT_ZERO)) begin
                            r_work  <= w_a_m;
                            r_cnt   <= w_cnt;
                            r_op    <= bus.op;
                            r_mode  <= bus.mode;
                            r_state <= ST_EXEC;
                        end else begin
                            r_result    <= w_res;
                            r_out_valid <= 1'b1;
                            r_state     <= ST_HOLD;
                            if (w_f_upd) begin
                                r_z <= w_z;
                                r_s <= w_s;
                            end else begin
                                r_z <= r_z;
                            end
                            if (w_c_upd) begin
                                r_c <= w_c;
                            end else begin
                                r_c <= r_c;
                            end
                        end
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_EXEC: begin
                    r_work <= w_step;
                    r_cnt  <= r_cnt - CNT_ONE;
                    if (r_cnt == CNT_ONE) begin
                        r_result    <= w_step;
                        r_z         <= (w_step == ZERO_W);
                        r_s         <= sign_bit(w_step, r_mode);
                        r_c         <= w_step_out;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_HOLD;
                    end else begin
                        r_state <= ST_EXEC;
                    end
                end
                ST_HOLD: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end else begin
                        r_state <= ST_HOLD;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_seq_alu_core.sv
// Scoreboard bench for seq_alu_core. The stimulus pushes hand-computed
// responses into a queue. A negedge monitor pops and compares them whenever
// the core presents a result.
module tb_seq_alu_core;
    localparam int WIDTH = 20;
    localparam int SHW   = 5;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    seq_alu_if #(.WIDTH(WIDTH), .SHW(SHW)) bus ();

    seq_alu_core #(.WIDTH(WIDTH), .SHW(SHW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        string       tag;
        logic [19:0] res;
        logic        z;
        logic        s;
        logic        c;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sbq[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    bit   seen     = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: compares every presented result against the front of the scoreboard.
    always @(negedge clk) begin
        if (bus.out_valid === 1'b1) begin
            if (sbq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_out_valid: got result 0x%0h expected no pending response", bus.result);
            end else begin
                if (!seen) begin
                    chk({"latency_", sbq[0].tag}, 32'(cyc - sbq[0].acc + 1), 32'(sbq[0].lat));
                    seen = 1'b1;
                end
                chk({"result_", sbq[0].tag}, 32'(bus.result), 32'(sbq[0].res));
                chk({"flag_z_", sbq[0].tag}, 32'(bus.flag_z), 32'(sbq[0].z));
                chk({"flag_s_", sbq[0].tag}, 32'(bus.flag_s), 32'(sbq[0].s));
                chk({"flag_c_", sbq[0].tag}, 32'(bus.flag_c), 32'(sbq[0].c));
                if (bus.out_ready === 1'b1) begin
                    void'(sbq.pop_front());
                    seen = 1'b0;
                end
            end
        end
    end

    // Drives one request. It pushes the expected response at the accept edge,
    // then waits (bounded) for the monitor to retire it.
    task automatic issue(input string tag, input logic [3:0] op, input logic md,
                         input logic [19:0] a, input logic [19:0] b, input logic [4:0] sh,
                         input logic [19:0] er, input logic ez, input logic es, input logic ec,
                         input int lat);
        exp_t e;
        int   n;
        bus.op       = op;
        bus.mode     = md;
        bus.a        = a;
        bus.b        = b;
        bus.shamt    = sh;
        bus.in_valid = 1'b1;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout_%s: got in_ready=%b expected 1", tag, bus.in_ready);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.a        = 20'($urandom);
        bus.b        = 20'($urandom);
        bus.shamt    = 5'($urandom);
        bus.op       = 4'($urandom);
        bus.mode     = ~md;
        e.tag = tag; e.res = er; e.z = ez; e.s = es; e.c = ec; e.lat = lat; e.acc = cyc;
        sbq.push_back(e);
        n = 0;
        while (sbq.size() != 0 && n < 100) begin
            chk({"in_ready_busy_", tag}, 32'(bus.in_ready), 32'(0));
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) begin
            checks++;
            failures++;
            $display("FAIL response_timeout_%s: got %0d pending expected 0", tag, sbq.size());
            sbq.delete();
            seen = 1'b0;
        end
    endtask

    // Watchdog: the run must never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1);
    end

    // Main stimulus sequence.
    initial begin
        exp_t e;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.op        = 4'h0;
        bus.mode      = 1'b1;
        bus.a         = 20'h00000;
        bus.b         = 20'h00000;
        bus.shamt     = 5'd0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(bus.in_ready), 32'(0));
        chk("rst_out_valid", 32'(bus.out_valid), 32'(0));
        chk("rst_result", 32'(bus.result), 32'(0));
        chk("rst_flags", 32'({bus.flag_z, bus.flag_s, bus.flag_c}), 32'(0));
        rst_n = 1'b1;
        #1;
        chk("rst_release_in_ready", 32'(bus.in_ready), 32'(1));

        //      tag          op    md    a          b          sh     result     Z     S     C     lat
        issue("add_full",  4'h4, 1'b1, 20'h7FFFF, 20'h00001, 5'd0,  20'h80000, 1'b0, 1'b1, 1'b0, 1);
        issue("add_half",  4'h4, 1'b0, 20'h003FF, 20'h00001, 5'd0,  20'h00000, 1'b1, 1'b0, 1'b1, 1);
        issue("adc_half",  4'h5, 1'b0, 20'h00001, 20'h00001, 5'd0,  20'h00003, 1'b0, 1'b0, 1'b0, 1);
        issue("rol_full",  4'hC, 1'b1, 20'h80001, 20'h00000, 5'd4,  20'h00018, 1'b0, 1'b0, 1'b0, 5);
        issue("shr_clamp", 4'hB, 1'b1, 20'hABCDE, 20'h00000, 5'd31, 20'h00000, 1'b1, 1'b0, 1'b1, 21);
        issue("sub_full",  4'h6, 1'b1, 20'h00005, 20'h00007, 5'd0,  20'hFFFFE, 1'b0, 1'b1, 1'b1, 1);
        issue("cmp_full",  4'hE, 1'b1, 20'h00005, 20'h00007, 5'd0,  20'h00005, 1'b0, 1'b1, 1'b1, 1);
        issue("sbc_full",  4'h7, 1'b1, 20'h00010, 20'h00003, 5'd0,  20'h0000C, 1'b0, 1'b0, 1'b0, 1);
        issue("inc_full",  4'h8, 1'b1, 20'hFFFFF, 20'h00000, 5'd0,  20'h00000, 1'b1, 1'b0, 1'b1, 1);
        issue("dec_half",  4'h9, 1'b0, 20'h12000, 20'h00000, 5'd0,  20'h003FF, 1'b0, 1'b1, 1'b1, 1);
        issue("xor_full",  4'h3, 1'b1, 20'hF0F0F, 20'hFFFFF, 5'd0,  20'h0F0F0, 1'b0, 1'b0, 1'b1, 1);
        issue("not_half",  4'h0, 1'b0, 20'h12345, 20'h00000, 5'd0,  20'h000BA, 1'b0, 1'b0, 1'b1, 1);
        issue("ror_half",  4'hD, 1'b0, 20'h00003, 20'h00000, 5'd2,  20'h00300, 1'b0, 1'b1, 1'b1, 3);
        issue("shl_half",  4'hA, 1'b0, 20'h00101, 20'h00000, 5'd1,  20'h00202, 1'b0, 1'b1, 1'b0, 2);
        issue("or_zero",   4'h2, 1'b1, 20'h00000, 20'h00000, 5'd0,  20'h00000, 1'b1, 1'b0, 1'b0, 1);
        issue("nop",       4'hF, 1'b1, 20'h00005, 20'h00007, 5'd0,  20'h00000, 1'b1, 1'b0, 1'b0, 1);
        issue("rol_cnt0",  4'hC, 1'b1, 20'h12345, 20'h00000, 5'd0,  20'h12345, 1'b0, 1'b0, 1'b0, 1);
        issue("and_full",  4'h1, 1'b1, 20'hF0F0F, 20'h0FF00, 5'd0,  20'h00F00, 1'b0, 1'b0, 1'b0, 1);

        // Backpressure: the result is held while out_ready=0 and no second accept happens.
        bus.out_ready = 1'b0;
        bus.op = 4'h4; bus.mode = 1'b1; bus.a = 20'h00001; bus.b = 20'h00002; bus.shamt = 5'd0;
        bus.in_valid = 1'b1;
        chk("bp_in_ready_idle", 32'(bus.in_ready), 32'(1));
        @(posedge clk); #1;
        e.tag = "bp_add"; e.res = 20'h00003; e.z = 1'b0; e.s = 1'b0; e.c = 1'b0; e.lat = 1; e.acc = cyc;
        sbq.push_back(e);
        bus.op = 4'h3; bus.a = 20'hFFFFF; bus.b = 20'h0000F;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("bp_in_ready_hold", 32'(bus.in_ready), 32'(0));
            chk("bp_out_valid_hold", 32'(bus.out_valid), 32'(1));
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_in_ready_resume", 32'(bus.in_ready), 32'(1));
        @(posedge clk); #1;
        e.tag = "bp_xor"; e.res = 20'hFFFF0; e.z = 1'b0; e.s = 1'b1; e.c = 1'b0; e.lat = 1; e.acc = cyc;
        sbq.push_back(e);
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("bp_drained", 32'(sbq.size()), 32'(0));

        // Reset mid-shift: the op is abandoned and every output clears.
        issue("pre_rst_sub", 4'h6, 1'b1, 20'h00005, 20'h00007, 5'd0, 20'hFFFFE, 1'b0, 1'b1, 1'b1, 1);
        bus.op = 4'hB; bus.mode = 1'b1; bus.a = 20'hABCDE; bus.b = 20'h00000; bus.shamt = 5'd10;
        bus.in_valid = 1'b1;
        chk("mid_rst_in_ready", 32'(bus.in_ready), 32'(1));
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready_low", 32'(bus.in_ready), 32'(0));
        @(posedge clk); #1;
        chk("mid_rst_out_valid", 32'(bus.out_valid), 32'(0));
        chk("mid_rst_result", 32'(bus.result), 32'(0));
        chk("mid_rst_flags", 32'({bus.flag_z, bus.flag_s, bus.flag_c}), 32'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", 32'(bus.in_ready), 32'(1));
        repeat (15) @(posedge clk);
        #1;
        issue("adc_after_rst", 4'h5, 1'b1, 20'h00001, 20'h00001, 5'd0, 20'h00002, 1'b0, 1'b0, 1'b0, 1);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
